// File: rtl/bigmem_par.sv
// Parametrised Unibus memory: NBLK enabled 4KB blocks on external 18-bit parity RAM,
// Unibus read parity checking and an auto-incrementing ARM load/dump port.
module bigmem_par #(
   parameter int unsigned NBLK   = 62,
   parameter int unsigned RAMLAT = 3
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        fpgaoff,
   input  logic        armwrite,
   input  logic [2:0]  armraddr,
   input  logic [2:0]  armwaddr,
   input  logic [31:0] armwdata,
   output logic [31:0] armrdata,
   input  logic [17:0] a_in_h,
   input  logic [1:0]  c_in_h,
   input  logic [15:0] d_in_h,
   input  logic        msyn_in_h,
   output logic [15:0] d_out_h,
   output logic        ssyn_out_h,
   output logic [16:0] extmemaddr,
   output logic [17:0] extmemdout,
   input  logic [17:0] extmemdin,
   output logic        extmemenab,
   output logic [1:0]  extmemwena
);

   localparam logic [63:0] EN_MASK = (NBLK >= 64) ? {64{1'b1}} : ((64'd1 << NBLK) - 64'd1);
   localparam logic [2:0]  LAST    = 3'(RAMLAT - 1);

   typedef enum logic [2:0] {IDLE, UWAIT, UDONE, UHOLD, AWAIT, ADONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt;
   logic [63:0] enable;
   logic [2:0]  armfunc;
   logic        autoinc;
   logic [3:0]  armcount;
   logic [17:0] armaddr;
   logic [15:0] armdata;
   logic        armpehi, armpelo;
   logic        pechk, pehalt, errvalid;
   logic [3:0]  errcount;
   logic [17:0] erraddr;
   logic [17:0] ua;
   logic        urd, ard;
   logic [5:0]  blk;
   logic        arm_go, ub_go, pf_hi, pf_lo, uerr;

   // Stored parity bit makes each 9-bit byte lane odd
   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   assign blk = a_in_h[17:12];

   always_comb begin
      arm_go = ~armwrite & (armfunc != 3'd0);
      ub_go  = ~arm_go & msyn_in_h & enable[blk] & ({1'b0, blk} < 7'(NBLK));
      pf_hi  = ~(^extmemdin[17:9]);
      pf_lo  = ~(^extmemdin[8:0]);
      uerr   = pechk & urd & (pf_hi | pf_lo);
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (arm_go) state_nxt = AWAIT;
                else if (ub_go) state_nxt = UWAIT;
         UWAIT: if (cnt == LAST) state_nxt = UDONE;
         UDONE: state_nxt = UHOLD;
         UHOLD: if (!msyn_in_h) state_nxt = IDLE;
         AWAIT: if (cnt == LAST) state_nxt = ADONE;
         ADONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (fpgaoff) state_nxt = IDLE;
   end

   // Datapath, ARM registers and RAM drive; ADONE's armfunc clear wins over a same-cycle write
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         cnt <= '0; enable <= '0; armfunc <= '0; autoinc <= 1'b0; armcount <= '0;
         armaddr <= '0; armdata <= '0; armpehi <= 1'b0; armpelo <= 1'b0;
         pechk <= 1'b0; pehalt <= 1'b0; errvalid <= 1'b0; errcount <= '0; erraddr <= '0;
         ua <= '0; urd <= 1'b0; ard <= 1'b0;
         d_out_h <= '0; ssyn_out_h <= 1'b0; extmemaddr <= '0; extmemdout <= '0;
         extmemenab <= 1'b0; extmemwena <= '0;
      end else begin
         if (armwrite) begin
            case (armwaddr)
               3'd1: enable[31:0]  <= armwdata & EN_MASK[31:0];
               3'd2: enable[63:32] <= armwdata & EN_MASK[63:32];
               3'd3: begin
                  armfunc <= armwdata[31:29];
                  autoinc <= armwdata[28];
                  armaddr <= armwdata[17:0];
               end
               3'd4: begin
                  armpehi <= armwdata[17];
                  armpelo <= armwdata[16];
                  armdata <= armwdata[15:0];
               end
               3'd5: begin
                  pechk  <= armwdata[31];
                  pehalt <= armwdata[30];
                  if (armwdata[29]) begin
                     errvalid <= 1'b0;
                     errcount <= '0;
                  end
               end
               default: ;
            endcase
         end

         if (fpgaoff) begin
            armfunc    <= '0;
            extmemenab <= 1'b0;
            extmemwena <= '0;
            d_out_h    <= '0;
            ssyn_out_h <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (arm_go) begin
                     extmemenab <= 1'b1;
                     extmemwena <= armfunc[1:0];
                     extmemaddr <= armaddr[17:1];
                     extmemdout <= {odd_par(armdata[15:8]) ^ armpehi, armdata[15:8],
                                    odd_par(armdata[7:0]) ^ armpelo, armdata[7:0]};
                     ard        <= armfunc[2];
                  end else if (ub_go) begin
                     extmemenab <= 1'b1;
                     extmemaddr <= a_in_h[17:1];
                     ua         <= a_in_h;
                     urd        <= ~c_in_h[1];
                     extmemdout <= {odd_par(d_in_h[15:8]), d_in_h[15:8],
                                    odd_par(d_in_h[7:0]), d_in_h[7:0]};
                     extmemwena <= c_in_h[1] ? {~c_in_h[0] | a_in_h[0], ~c_in_h[0] | ~a_in_h[0]}
                                             : 2'b00;
                  end
               end
               UWAIT, AWAIT: cnt <= cnt + 3'd1;
               UDONE: begin
                  extmemenab <= 1'b0;
                  extmemwena <= '0;
                  if (urd) d_out_h <= {extmemdin[16:9], extmemdin[7:0]};
                  if (uerr) begin
                     errvalid <= 1'b1;
                     if (errcount != 4'hF) errcount <= errcount + 4'd1;
                     if (!errvalid) erraddr <= ua;
                  end
                  ssyn_out_h <= msyn_in_h & ~(uerr & pehalt);
               end
               UHOLD: if (!msyn_in_h) begin
                  d_out_h    <= '0;
                  ssyn_out_h <= 1'b0;
               end
               ADONE: begin
                  extmemenab <= 1'b0;
                  extmemwena <= '0;
                  if (ard) begin
                     armdata <= {extmemdin[16:9], extmemdin[7:0]};
                     armpehi <= pf_hi;
                     armpelo <= pf_lo;
                  end
                  armcount <= armcount + 4'd1;
                  armfunc  <= '0;
                  if (autoinc) armaddr <= armaddr + 18'd2;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      armrdata = 32'hDEADBEEF;
      case (armraddr)
         3'd0: armrdata = 32'h424D2006;
         3'd1: armrdata = enable[31:0];
         3'd2: armrdata = enable[63:32];
         3'd3: armrdata = {armfunc, autoinc, armcount, 6'b0, armaddr};
         3'd4: armrdata = {14'b0, armpehi, armpelo, armdata};
         3'd5: armrdata = {pechk, pehalt, errvalid, 1'b0, errcount, 6'b0, erraddr};
         default: armrdata = 32'hDEADBEEF;
      endcase
   end

endmodule

// File: tb/tb_bigmem_par.sv
// Self-checking bench for bigmem_par: behavioural parity RAM, Unibus/ARM tasks and
// scoreboard queues of expected read data.
module tb_bigmem_par;

   localparam int unsigned NBLK   = 8;
   localparam int unsigned RAMLAT = 3;

   logic        CLOCK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        fpgaoff = 1'b0;
   logic        armwrite = 1'b0;
   logic [2:0]  armraddr = '0, armwaddr = '0;
   logic [31:0] armwdata = '0;
   logic [31:0] armrdata;
   logic [17:0] a_in_h = '0;
   logic [1:0]  c_in_h = '0;
   logic [15:0] d_in_h = '0;
   logic        msyn_in_h = 1'b0;
   logic [15:0] d_out_h;
   logic        ssyn_out_h;
   logic [16:0] extmemaddr;
   logic [17:0] extmemdout;
   logic [17:0] ram_q = '0;
   logic        extmemenab;
   logic [1:0]  extmemwena;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_ud[$];
   logic [31:0] exp_arm[$];
   logic [17:0] mem [0:16383];

   bigmem_par #(.NBLK(NBLK), .RAMLAT(RAMLAT)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .fpgaoff(fpgaoff),
      .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
      .armwdata(armwdata), .armrdata(armrdata),
      .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h), .msyn_in_h(msyn_in_h),
      .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h),
      .extmemaddr(extmemaddr), .extmemdout(extmemdout), .extmemdin(ram_q),
      .extmemenab(extmemenab), .extmemwena(extmemwena)
   );

   always #5 CLOCK = ~CLOCK;

   // Synchronous RAM with per-byte-lane writes; read returns the pre-write word
   always @(posedge CLOCK) begin
      if (extmemenab) begin
         ram_q <= mem[extmemaddr[13:0]];
         if (extmemwena[1]) mem[extmemaddr[13:0]][17:9] <= extmemdout[17:9];
         if (extmemwena[0]) mem[extmemaddr[13:0]][8:0]  <= extmemdout[8:0];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic arm_wr(input logic [2:0] idx, input logic [31:0] data);
      @(negedge CLOCK);
      armwaddr = idx; armwdata = data; armwrite = 1'b1;
      @(negedge CLOCK);
      armwrite = 1'b0;
   endtask

   task automatic arm_rd(input logic [2:0] idx, output logic [31:0] data);
      @(negedge CLOCK);
      armraddr = idx;
      #1 data = armrdata;
   endtask

   // Starts an ARM access and waits for armfunc to clear
   task automatic arm_cmd(input logic [31:0] cmd, input logic is_rd, input logic [31:0] exp4,
                          input string tag);
      int e;
      logic [31:0] r, want;
      if (is_rd) exp_arm.push_back(exp4);
      arm_wr(3'd3, cmd);
      armraddr = 3'd3;
      e = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge CLOCK); @(negedge CLOCK);
         if (armrdata[31:29] == 3'd0) begin e = n; break; end
      end
      chk({tag, "_edges"}, 32'(e), 32'(RAMLAT + 2));
      if (is_rd) begin
         arm_rd(3'd4, r);
         want = exp_arm.pop_front();
         chk({tag, "_reg4"}, r, want);
      end
   endtask

   task automatic ub_cycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                           input int maxw, output int ssyn_edge, output logic [1:0] wena,
                           output logic enab_seen, output logic [17:0] dout_seen);
      @(negedge CLOCK);
      a_in_h = a; c_in_h = c; d_in_h = d; msyn_in_h = 1'b1;
      ssyn_edge = 0; wena = '0; enab_seen = 1'b0; dout_seen = '0;
      for (int n = 1; n <= maxw; n++) begin
         @(posedge CLOCK); @(negedge CLOCK);
         if (extmemenab && !enab_seen) begin
            enab_seen = 1'b1; wena = extmemwena; dout_seen = extmemdout;
         end
         if (ssyn_out_h) begin ssyn_edge = n; break; end
      end
   endtask

   task automatic ub_release(input string tag);
      @(negedge CLOCK);
      msyn_in_h = 1'b0;
      @(posedge CLOCK); @(negedge CLOCK);
      chk({tag, "_ssyn_drop"}, {31'd0, ssyn_out_h}, 32'd0);
      @(posedge CLOCK); @(negedge CLOCK);
   endtask

   task automatic ub_read(input logic [17:0] a, input logic [15:0] exp, input string tag);
      int e;
      logic [1:0] w;
      logic en;
      logic [17:0] dx;
      logic [31:0] want;
      exp_ud.push_back({16'd0, exp});
      ub_cycle(a, 2'b00, 16'd0, 20, e, w, en, dx);
      chk({tag, "_edges"}, 32'(e), 32'(RAMLAT + 2));
      want = exp_ud.pop_front();
      chk({tag, "_data"}, {16'd0, d_out_h}, want);
      ub_release(tag);
   endtask

   initial begin
      int e;
      logic [1:0] w;
      logic en;
      logic [17:0] dx;
      logic [31:0] r;

      for (int i = 0; i < 16384; i++) mem[i] = {1'b1, 8'h00, 1'b1, 8'h00};
      repeat (3) @(posedge CLOCK);
      @(negedge CLOCK);
      chk("rst_ssyn", {31'd0, ssyn_out_h}, 32'd0);
      chk("rst_dout", {16'd0, d_out_h}, 32'd0);
      chk("rst_enab", {31'd0, extmemenab}, 32'd0);
      RESET_N = 1'b1;
      arm_rd(3'd0, r); chk("reg0_id", r, 32'h424D2006);
      arm_rd(3'd3, r); chk("rst_reg3", r, 32'd0);
      arm_rd(3'd5, r); chk("rst_reg5", r, 32'd0);
      arm_rd(3'd6, r); chk("reg6", r, 32'hDEADBEEF);

      arm_wr(3'd1, 32'd1);
      arm_rd(3'd1, r); chk("reg1_en", r, 32'd1);

      // Word write then readback
      ub_cycle(18'o001000, 2'b10, 16'o123456, 20, e, w, en, dx);
      chk("uw_edges", 32'(e), 32'(RAMLAT + 2));
      chk("uw_wena", {30'd0, w}, 32'd3);
      chk("uw_dout", {14'd0, dx}, {14'd0, 1'b0, 8'hA7, 1'b1, 8'h2E});
      ub_release("uw");
      ub_read(18'o001000, 16'o123456, "ur1");

      // High-byte write keeps the low byte
      ub_cycle(18'o001001, 2'b11, 16'hAB00, 20, e, w, en, dx);
      chk("ub_wena", {30'd0, w}, 32'd2);
      ub_release("ub");
      ub_read(18'o001000, 16'hAB2E, "ur2");

      // ARM write with bad low parity, then auto-incrementing reads
      arm_wr(3'd4, 32'h0001_5555);
      arm_cmd(32'h7000_0000, 1'b0, 32'd0, "aw0");
      arm_rd(3'd3, r); chk("aw0_reg3", r, 32'h1100_0002);
      arm_cmd(32'h9000_0000, 1'b1, 32'h0001_5555, "ar0");
      arm_rd(3'd3, r); chk("ar0_reg3", r, 32'h1200_0002);
      arm_cmd(32'h9000_0002, 1'b1, 32'h0000_0000, "ar2");
      arm_rd(3'd3, r); chk("ar2_reg3", r, 32'h1300_0004);
      arm_cmd(32'h9000_0004, 1'b1, 32'h0000_0000, "ar4");
      arm_rd(3'd3, r); chk("ar4_reg3", r, 32'h1400_0006);

      // Second bad word (high parity) at 0o100
      arm_wr(3'd4, 32'h0002_1234);
      arm_cmd(32'h6000_0040, 1'b0, 32'd0, "aw40");
      arm_rd(3'd3, r); chk("aw40_reg3", r, 32'h0500_0040);

      // Parity checking without halt
      arm_wr(3'd5, 32'h8000_0000);
      ub_read(18'o000000, 16'h5555, "pe1");
      arm_rd(3'd5, r); chk("pe1_reg5", r, 32'hA100_0000);
      ub_read(18'o000100, 16'h1234, "pe2");
      arm_rd(3'd5, r); chk("pe2_reg5", r, 32'hA200_0000);
      arm_wr(3'd5, 32'hA000_0000);
      arm_rd(3'd5, r); chk("pe_clear", r, 32'h8000_0000);

      // Halt mode withholds SSYN
      arm_wr(3'd5, 32'hC000_0000);
      ub_cycle(18'o000000, 2'b00, 16'd0, 12, e, w, en, dx);
      chk("halt_nossyn", 32'(e), 32'd0);
      chk("halt_enab", {31'd0, en}, 32'd1);
      ub_release("halt");
      arm_rd(3'd5, r); chk("halt_reg5", r, 32'hE100_0000);
      arm_wr(3'd5, 32'h0000_0000);

      // Disabled block and block beyond NBLK
      ub_cycle(18'o010000, 2'b00, 16'd0, 10, e, w, en, dx);
      chk("dis_enab", {31'd0, en}, 32'd0);
      chk("dis_ssyn", 32'(e), 32'd0);
      ub_release("dis");
      arm_wr(3'd1, 32'hFFFF_FFFF);
      arm_rd(3'd1, r); chk("reg1_mask", r, 32'h0000_00FF);
      arm_wr(3'd2, 32'hFFFF_FFFF);
      arm_rd(3'd2, r); chk("reg2_mask", r, 32'd0);
      ub_cycle(18'o100000, 2'b00, 16'd0, 10, e, w, en, dx);
      chk("nblk_enab", {31'd0, en}, 32'd0);
      chk("nblk_ssyn", 32'(e), 32'd0);
      ub_release("nblk");
      ub_read(18'o010000, 16'h0000, "blk1");

      // fpgaoff during AWAIT
      arm_wr(3'd3, 32'h8000_0000);
      @(posedge CLOCK); @(posedge CLOCK);
      @(negedge CLOCK); fpgaoff = 1'b1;
      @(negedge CLOCK); fpgaoff = 1'b0;
      chk("off_enab", {31'd0, extmemenab}, 32'd0);
      arm_rd(3'd3, r); chk("off_reg3", r, 32'h0500_0000);
      repeat (8) @(posedge CLOCK);
      arm_rd(3'd3, r); chk("off_reg3_late", r, 32'h0500_0000);
      arm_rd(3'd1, r); chk("off_keep_en", r, 32'h0000_00FF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
